// File: rtl/ac97_pkg.sv
// Shared AC97 link constants: frame geometry, slot end positions and link state encoding.
package ac97_pkg;

  localparam int FRAME_BITS = 256;
  localparam int TAG_BITS   = 16;
  localparam int SLOT_BITS  = 20;

  // bit_cnt value at which each field's last bit arrives
  localparam logic [7:0] TAG_END   = 8'd15;
  localparam logic [7:0] SLOT1_END = 8'd35;
  localparam logic [7:0] SLOT2_END = 8'd55;
  localparam logic [7:0] SLOT3_END = 8'd75;
  localparam logic [7:0] SLOT4_END = 8'd95;
  localparam logic [7:0] FRAME_END = 8'd255;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    RECEIVE = 1'b1
  } ac97_state_e;

  // Tag bits 14:3 arrive slot 1 first; reverse so that bit 0 = slot 1.
  function automatic logic [11:0] tag_to_valid(input logic [11:0] tag_14_3);
    logic [11:0] v;
    for (int i = 0; i < 12; i++) begin
      v[i] = tag_14_3[11-i];
    end
    return v;
  endfunction

endpackage

// File: rtl/ac97_slot_shifter.sv
// 20-bit MSB-first serial-in shift register; word presents the value including the current bit.
module ac97_slot_shifter
  import ac97_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 din,
  output logic [SLOT_BITS-1:0] word
);

  logic [SLOT_BITS-1:0] shift_r;

  assign word = {shift_r[SLOT_BITS-2:0], din};

  // shift state, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= {SLOT_BITS{1'b0}};
    end else if (shift_en) begin
      shift_r <= word;
    end else begin
      shift_r <= shift_r;
    end
  end

endmodule

// File: rtl/ac97_sdata_in_deframer.sv
// AC97 SDATA_IN deframer: aligns to ac97_synch, extracts tag, status and PCM slots, publishes per frame.
// Optional macro AC97_RX_ERR_COUNT_EN enables the saturating sync_err_count.
module ac97_sdata_in_deframer
  import ac97_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 18
) (
  input  logic                    ac97_bit_clock,
  input  logic                    reset,
  input  logic                    ac97_synch,
  input  logic                    ac97_sdata_in,
  output logic                    locked,
  output logic                    codec_ready,
  output logic [11:0]             tag_valid,
  output logic [6:0]              status_addr,
  output logic [15:0]             status_data,
  output logic [SAMPLE_WIDTH-1:0] pcm_left,
  output logic [SAMPLE_WIDTH-1:0] pcm_right,
  output logic                    frame_strobe,
  output logic                    status_strobe,
  output logic                    sample_strobe,
  output logic                    sync_error,
  output logic [7:0]              sync_err_count
);

  ac97_state_e             state_r;
  logic [7:0]              bit_cnt_r;
  logic                    sync_prev_r;
  logic [12:0]             tag_stage_r;   // tag bits 15:3
  logic [6:0]              addr_stage_r;
  logic [15:0]             data_stage_r;
  logic [SAMPLE_WIDTH-1:0] left_stage_r;
  logic [SAMPLE_WIDTH-1:0] right_stage_r;
  logic [SLOT_BITS-1:0]    shift_word_s;
  logic [2:0]              tag_id_unused_s;
  logic                    receiving_s;
  logic                    sync_edge_s;
  logic                    fault_s;
  logic                    status_ok_s;
  logic                    sample_ok_s;

  assign receiving_s     = (state_r == RECEIVE);
  assign sync_edge_s     = ac97_synch & ~sync_prev_r;
  assign fault_s         = receiving_s & ((bit_cnt_r == FRAME_END) ? ~sync_edge_s : sync_edge_s);
  assign status_ok_s     = tag_stage_r[11] & tag_stage_r[10];
  assign sample_ok_s     = tag_stage_r[9] & tag_stage_r[8];
  assign tag_id_unused_s = shift_word_s[2:0];

  ac97_slot_shifter u_shifter (
    .clk      (ac97_bit_clock),
    .reset    (reset),
    .shift_en (receiving_s),
    .din      (ac97_sdata_in),
    .word     (shift_word_s)
  );

  // capture each field as its last bit arrives
  always_ff @(posedge ac97_bit_clock) begin
    if (reset) begin
      tag_stage_r   <= 13'd0;
      addr_stage_r  <= 7'd0;
      data_stage_r  <= 16'd0;
      left_stage_r  <= {SAMPLE_WIDTH{1'b0}};
      right_stage_r <= {SAMPLE_WIDTH{1'b0}};
    end else if (receiving_s) begin
      case (bit_cnt_r)
        TAG_END:   tag_stage_r   <= shift_word_s[15:3];
        SLOT1_END: addr_stage_r  <= shift_word_s[18:12];
        SLOT2_END: data_stage_r  <= shift_word_s[19:4];
        SLOT3_END: left_stage_r  <= shift_word_s[SLOT_BITS-1 -: SAMPLE_WIDTH];
        SLOT4_END: right_stage_r <= shift_word_s[SLOT_BITS-1 -: SAMPLE_WIDTH];
        default:   tag_stage_r   <= tag_stage_r;
      endcase
    end
  end

  // alignment FSM and registered publication of a completed frame
  always_ff @(posedge ac97_bit_clock) begin
    if (reset) begin
      state_r       <= HUNT;
      bit_cnt_r     <= 8'd0;
      sync_prev_r   <= 1'b0;
      locked        <= 1'b0;
      codec_ready   <= 1'b0;
      tag_valid     <= 12'd0;
      status_addr   <= 7'd0;
      status_data   <= 16'd0;
      pcm_left      <= {SAMPLE_WIDTH{1'b0}};
      pcm_right     <= {SAMPLE_WIDTH{1'b0}};
      frame_strobe  <= 1'b0;
      status_strobe <= 1'b0;
      sample_strobe <= 1'b0;
      sync_error    <= 1'b0;
    end else begin
      sync_prev_r   <= ac97_synch;
      frame_strobe  <= 1'b0;
      status_strobe <= 1'b0;
      sample_strobe <= 1'b0;
      sync_error    <= fault_s;
      case (state_r)
        HUNT: begin
          bit_cnt_r <= 8'd0;
          if (sync_edge_s) begin
            state_r <= RECEIVE;
            locked  <= 1'b1;
          end
        end
        RECEIVE: begin
          if (bit_cnt_r == FRAME_END) begin
            bit_cnt_r    <= 8'd0;
            codec_ready  <= tag_stage_r[12];
            tag_valid    <= tag_to_valid(tag_stage_r[11:0]);
            frame_strobe <= 1'b1;
            // status and PCM fields only move when the codec flagged them valid
            if (status_ok_s) begin
              status_addr   <= addr_stage_r;
              status_data   <= data_stage_r;
              status_strobe <= 1'b1;
            end
            if (sample_ok_s) begin
              pcm_left      <= left_stage_r;
              pcm_right     <= right_stage_r;
              sample_strobe <= 1'b1;
            end
            if (!sync_edge_s) begin
              state_r <= HUNT;
              locked  <= 1'b0;
            end
          end else if (sync_edge_s) begin
            bit_cnt_r <= 8'd0;
          end else begin
            bit_cnt_r <= bit_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r   <= HUNT;
          bit_cnt_r <= 8'd0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

`ifdef AC97_RX_ERR_COUNT_EN
  logic [7:0] err_count_r;

  // saturating alignment-fault counter
  always_ff @(posedge ac97_bit_clock) begin
    if (reset) begin
      err_count_r <= 8'd0;
    end else if (fault_s && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'd1;
    end
  end

  assign sync_err_count = err_count_r;
`else
  assign sync_err_count = 8'd0;
`endif

endmodule

// File: tb/tb_ac97_sdata_in_deframer.sv
// Directed bench for ac97_sdata_in_deframer: clean frames, tag gating, early/withheld sync, error saturation, reset.
module tb_ac97_sdata_in_deframer;

  logic        ac97_bit_clock;
  logic        reset;
  logic        ac97_synch;
  logic        ac97_sdata_in;
  logic        locked;
  logic        codec_ready;
  logic [11:0] tag_valid;
  logic [6:0]  status_addr;
  logic [15:0] status_data;
  logic [17:0] pcm_left;
  logic [17:0] pcm_right;
  logic        frame_strobe;
  logic        status_strobe;
  logic        sample_strobe;
  logic        sync_error;
  logic [7:0]  sync_err_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

`ifdef AC97_RX_ERR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  ac97_sdata_in_deframer #(.SAMPLE_WIDTH(18)) dut (
    .ac97_bit_clock (ac97_bit_clock),
    .reset          (reset),
    .ac97_synch     (ac97_synch),
    .ac97_sdata_in  (ac97_sdata_in),
    .locked         (locked),
    .codec_ready    (codec_ready),
    .tag_valid      (tag_valid),
    .status_addr    (status_addr),
    .status_data    (status_data),
    .pcm_left       (pcm_left),
    .pcm_right      (pcm_right),
    .frame_strobe   (frame_strobe),
    .status_strobe  (status_strobe),
    .sample_strobe  (sample_strobe),
    .sync_error     (sync_error),
    .sync_err_count (sync_err_count)
  );

  initial ac97_bit_clock = 1'b0;
  always #5 ac97_bit_clock = ~ac97_bit_clock;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one bit at a negedge, return at the following negedge (after the sampling posedge)
  task automatic send_bit(input logic s, input logic d);
    ac97_synch    = s;
    ac97_sdata_in = d;
    @(negedge ac97_bit_clock);
  endtask

  // send frame bits first..last-1; synch pulses on the final bit sent when end_sync
  task automatic send_frame(input int first, input int last, input bit end_sync,
                            input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                            input logic [19:0] s3, input logic [19:0] s4);
    for (int k = first; k < last; k++) begin
      logic d;
      int   sl;
      int   p;
      sl = (k - 16) / 20;
      p  = 19 - ((k - 16) % 20);
      if (k < 16) d = tag[15-k];
      else if (k < 96) begin
        case (sl)
          0:       d = s1[p];
          1:       d = s2[p];
          2:       d = s3[p];
          default: d = s4[p];
        endcase
      end else d = 1'($urandom_range(0, 1));
      send_bit(end_sync && (k == last - 1), d);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_locked"}, 32'(locked), 32'd0);
    chk({pfx, "_codec_ready"}, 32'(codec_ready), 32'd0);
    chk({pfx, "_tag_valid"}, 32'(tag_valid), 32'd0);
    chk({pfx, "_status_addr"}, 32'(status_addr), 32'd0);
    chk({pfx, "_status_data"}, 32'(status_data), 32'd0);
    chk({pfx, "_pcm_left"}, 32'(pcm_left), 32'd0);
    chk({pfx, "_pcm_right"}, 32'(pcm_right), 32'd0);
    chk({pfx, "_frame_strobe"}, 32'(frame_strobe), 32'd0);
    chk({pfx, "_status_strobe"}, 32'(status_strobe), 32'd0);
    chk({pfx, "_sample_strobe"}, 32'(sample_strobe), 32'd0);
    chk({pfx, "_sync_error"}, 32'(sync_error), 32'd0);
    chk({pfx, "_err_count"}, 32'(sync_err_count), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    ac97_synch    = 1'b0;
    ac97_sdata_in = 1'b0;
    @(negedge ac97_bit_clock);
    @(negedge ac97_bit_clock);
    check_all_zero("reset");

    // hunt, then lock on the first sync edge
    reset = 1'b0;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    chk("hunt_locked", 32'(locked), 32'd0);
    send_bit(1'b1, 1'b0);
    chk("lock_locked", 32'(locked), 32'd1);

    // frame A: all of slots 1-4 valid
    send_frame(0, 256, 1'b1, 16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'hABCDE);
    chk("A_codec_ready", 32'(codec_ready), 32'd1);
    chk("A_tag_valid", 32'(tag_valid), 32'h00F);
    chk("A_status_addr", 32'(status_addr), 32'h26);
    chk("A_status_data", 32'(status_data), 32'h000F);
    chk("A_pcm_left", 32'(pcm_left), 32'h048D1);
    chk("A_pcm_right", 32'(pcm_right), 32'h2AF37);
    chk("A_frame_strobe", 32'(frame_strobe), 32'd1);
    chk("A_status_strobe", 32'(status_strobe), 32'd1);
    chk("A_sample_strobe", 32'(sample_strobe), 32'd1);
    chk("A_sync_error", 32'(sync_error), 32'd0);
    chk("A_locked", 32'(locked), 32'd1);

    // frame B: only slots 1,2 valid; strobes from A must be gone after one cycle
    send_frame(0, 1, 1'b0, 16'hE000, 20'h1C000, 20'hBEEF0, 20'h55555, 20'h0AAAA);
    chk("A_frame_strobe_1cyc", 32'(frame_strobe), 32'd0);
    chk("A_status_strobe_1cyc", 32'(status_strobe), 32'd0);
    chk("A_sample_strobe_1cyc", 32'(sample_strobe), 32'd0);
    send_frame(1, 256, 1'b1, 16'hE000, 20'h1C000, 20'hBEEF0, 20'h55555, 20'h0AAAA);
    chk("B_tag_valid", 32'(tag_valid), 32'h003);
    chk("B_status_addr", 32'(status_addr), 32'h1C);
    chk("B_status_data", 32'(status_data), 32'hBEEF);
    chk("B_frame_strobe", 32'(frame_strobe), 32'd1);
    chk("B_status_strobe", 32'(status_strobe), 32'd1);
    chk("B_sample_strobe", 32'(sample_strobe), 32'd0);
    chk("B_pcm_left_hold", 32'(pcm_left), 32'h048D1);
    chk("B_pcm_right_hold", 32'(pcm_right), 32'h2AF37);

    // early sync at bit_cnt 100
    send_frame(0, 101, 1'b1, 16'hF800, 20'h7F000, 20'h11110, 20'h00000, 20'h00000);
    chk("early_sync_error", 32'(sync_error), 32'd1);
    chk("early_frame_strobe", 32'(frame_strobe), 32'd0);
    chk("early_locked", 32'(locked), 32'd1);
    chk("early_status_hold", 32'(status_addr), 32'h1C);
    chk("early_err_count", 32'(sync_err_count), CNT_EN ? 32'd1 : 32'd0);

    // frame C decodes after the early sync; sync withheld at its end
    send_frame(0, 1, 1'b0, 16'hF800, 20'h02000, 20'h12340, 20'hFFFFF, 20'h00003);
    chk("early_error_1cyc", 32'(sync_error), 32'd0);
    send_frame(1, 256, 1'b0, 16'hF800, 20'h02000, 20'h12340, 20'hFFFFF, 20'h00003);
    chk("C_frame_strobe", 32'(frame_strobe), 32'd1);
    chk("C_sample_strobe", 32'(sample_strobe), 32'd1);
    chk("C_status_addr", 32'(status_addr), 32'h02);
    chk("C_status_data", 32'(status_data), 32'h1234);
    chk("C_pcm_left", 32'(pcm_left), 32'h3FFFF);
    chk("C_pcm_right", 32'(pcm_right), 32'h00000);
    chk("C_sync_error", 32'(sync_error), 32'd1);
    chk("C_locked", 32'(locked), 32'd0);
    chk("C_err_count", 32'(sync_err_count), CNT_EN ? 32'd2 : 32'd0);

    // hunting: no frames, outputs hold
    repeat (5) send_bit(1'b0, 1'b1);
    chk("hunt2_locked", 32'(locked), 32'd0);
    chk("hunt2_frame_strobe", 32'(frame_strobe), 32'd0);
    chk("hunt2_status_hold", 32'(status_data), 32'h1234);

    // relock and frame D: only slots 3,4 valid
    send_bit(1'b1, 1'b0);
    chk("relock_locked", 32'(locked), 32'd1);
    send_frame(0, 256, 1'b1, 16'h9800, 20'h00000, 20'h00000, 20'h80000, 20'h00004);
    chk("D_tag_valid", 32'(tag_valid), 32'h00C);
    chk("D_status_strobe", 32'(status_strobe), 32'd0);
    chk("D_sample_strobe", 32'(sample_strobe), 32'd1);
    chk("D_pcm_left", 32'(pcm_left), 32'h20000);
    chk("D_pcm_right", 32'(pcm_right), 32'h00001);
    chk("D_status_hold", 32'(status_addr), 32'h02);
    chk("D_sync_error", 32'(sync_error), 32'd0);

    // 300 early-sync faults; 253 more bring the count from 2 to 255
    repeat (253) begin
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
    end
    chk("sat_edge_count", 32'(sync_err_count), CNT_EN ? 32'd255 : 32'd0);
    repeat (47) begin
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
    end
    chk("sat_count", 32'(sync_err_count), CNT_EN ? 32'd255 : 32'd0);
    chk("sat_sync_error", 32'(sync_error), 32'd1);
    chk("sat_locked", 32'(locked), 32'd1);

    // reset asserted at bit_cnt 50
    send_frame(0, 50, 1'b0, 16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'hABCDE);
    reset = 1'b1;
    send_bit(1'b0, 1'b1);
    check_all_zero("midrst");
    reset = 1'b0;
    repeat (3) send_bit(1'b0, 1'b1);
    check_all_zero("postrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
